mem_port_arbiter: RTL and testbench

// - Shares the CPU's single unified memory port between two requesters: instruction fetch (I) and load/store data (D).
// - Sits between the PC/fetch logic, the load/store datapath and the memory macro.
// - Memory has a fixed read/write latency. The arbiter sequences each access with an FSM and returns the result with a one-cycle valid pulse.

---
 rtl/mem_port_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one unified memory port between instruction fetch (I) and
// load/store data (D). Each access runs IDLE -> ISSUE -> WAIT -> DONE:
// a single mem_en strobe, MEM_LAT cycles of waiting, then a one-cycle
// valid pulse to the owner. Back-to-back grants are MEM_LAT+3 cycles apart.
//
// Ports
//   clk, rst                    clock (rising), async active-high reset
//   hlt                         blocks new I grants (D still served)
//   i_req/i_addr                fetch request (level) and address
//   i_rdata/i_valid             fetched word (held) and completion pulse
//   d_req/d_wr/d_addr/d_wdata   load/store request
//   d_rdata/d_valid             load data (held) and completion pulse
//   mem_en/mem_wr               one-cycle access strobe and write qualifier
//   mem_addr/mem_wdata          held from grant to completion
//   mem_rdata                   memory read data, valid MEM_LAT after mem_en
//   busy                        high whenever an access is in progress
//
// Configuration macro: MEM_ARB_RR_EN
//   undefined : fixed priority, D over I (sustained D can starve I)
//   defined   : round-robin on conflict; lone requester always granted

module mem_port_arbiter #(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 16,
   parameter int MEM_LAT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              hlt,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [DATA_W-1:0] i_rdata,
   output logic              i_valid,
   input  logic              d_req,
   input  logic              d_wr,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_valid,
   output logic              mem_en,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   localparam int CNT_W = $clog2(MEM_LAT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   // owner / last_grant encoding: 1 = D, 0 = I
   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              owner_q, owner_d;
   logic              last_grant_q, last_grant_d;
   logic              wr_q, wr_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

   logic i_elig, d_elig, grant_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         owner_q      <= 1'b0;
         last_grant_q <= 1'b1;
         wr_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         i_rdata_q    <= '0;
         d_rdata_q    <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         wr_q         <= wr_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         i_rdata_q    <= i_rdata_d;
         d_rdata_q    <= d_rdata_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      wr_d         = wr_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      i_rdata_d    = i_rdata_q;
      d_rdata_d    = d_rdata_q;

      i_elig = i_req & ~hlt;
      d_elig = d_req;
`ifdef MEM_ARB_RR_EN
      // On conflict, favour whoever did not own the previous access.
      grant_d = d_elig & (~i_elig | ~last_grant_q);
`else
      grant_d = d_elig;
`endif

      case (state_q)
         S_IDLE: begin
            if (i_elig | d_elig) begin
               state_d      = S_ISSUE;
               owner_d      = grant_d;
               last_grant_d = grant_d;
               addr_d       = grant_d ? d_addr : i_addr;
               wr_d         = grant_d & d_wr;
               if (grant_d)
                  wdata_d = d_wdata;
            end
         end
         S_ISSUE: begin
            state_d = S_WAIT;
            cnt_d   = CNT_ONE;
         end
         S_WAIT: begin
            if (cnt_q == CNT_LAST) begin
               state_d = S_DONE;
               // Stores leave both read-data registers untouched.
               if (!wr_q) begin
                  if (owner_q) d_rdata_d = mem_rdata;
                  else         i_rdata_d = mem_rdata;
               end
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Strobes decode straight from state so an async reset clears them at once.
   assign mem_en    = (state_q == S_ISSUE);
   assign mem_wr    = mem_en & wr_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign i_valid   = (state_q == S_DONE) & ~owner_q;
   assign d_valid   = (state_q == S_DONE) &  owner_q;
   assign i_rdata   = i_rdata_q;
   assign d_rdata   = d_rdata_q;
   assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: a MEM_LAT=4 instance exercised with
// directed and randomized accesses, plus a MEM_LAT=1 instance for the
// minimum-latency back-to-back case. A behavioural memory answers each
// DUT; expected values come from a shadow copy of memory kept by the bench.

module tb_mem_port_arbiter;

   localparam int LAT  = 4;
   localparam int LAT1 = 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // DUT 0 (MEM_LAT=4)
   logic        hlt = 0, i_req = 0, d_req = 0, d_wr = 0;
   logic [15:0] i_addr = 0, d_addr = 0, d_wdata = 0;
   logic [15:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
   logic        i_valid, d_valid, mem_en, mem_wr, busy;

   // DUT 1 (MEM_LAT=1)
   logic        i_req1 = 0;
   logic [15:0] i_addr1 = 0;
   logic [15:0] i_rdata1, d_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
   logic        i_valid1, d_valid1, mem_en1, mem_wr1, busy1;

   mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(LAT)) u_dut (
      .clk(clk), .rst(rst), .hlt(hlt),
      .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_valid(i_valid),
      .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_valid(d_valid),
      .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy));

   mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(LAT1)) u_dut1 (
      .clk(clk), .rst(rst), .hlt(1'b0),
      .i_req(i_req1), .i_addr(i_addr1), .i_rdata(i_rdata1), .i_valid(i_valid1),
      .d_req(1'b0), .d_wr(1'b0), .d_addr(16'h0000), .d_wdata(16'h0000),
      .d_rdata(d_rdata1), .d_valid(d_valid1),
      .mem_en(mem_en1), .mem_wr(mem_wr1), .mem_addr(mem_addr1),
      .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1), .busy(busy1));

   // Memory contents (seen by the DUT) and the bench's shadow expectation.
   logic [15:0] mem0    [0:65535];
   logic [15:0] ref_mem [0:65535];
   logic [15:0] pipe0 [1:LAT];
   logic [15:0] pipe1;

   // Read data appears LAT cycles after the mem_en cycle; filler otherwise.
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_wr) mem0[mem_addr] <= mem_wdata;
         pipe0[1] <= mem0[mem_addr];
      end else begin
         pipe0[1] <= 16'($urandom);
      end
      for (int k = 2; k <= LAT; k++) pipe0[k] <= pipe0[k-1];
      pipe1 <= mem_en1 ? mem0[mem_addr1] : 16'($urandom);
   end
   assign mem_rdata  = pipe0[LAT];
   assign mem_rdata1 = pipe1;

   int wr_viol = 0;
   always @(negedge clk) begin
      if ((mem_wr && !mem_en) || (mem_wr1 && !mem_en1)) wr_viol <= wr_viol + 1;
   end

   int tests = 0;
   int fails = 0;

   // One complete access on DUT 0 from an idle port, checked for grant
   // timing, completion latency, write qualifier and data.
   task automatic access(input bit is_d, input bit wr, input logic [15:0] addr,
                         input logic [15:0] wdata, input string nm);
      int n, en_at;
      bit got, wr_at_en;
      logic [15:0] prev_i, prev_d;
      prev_i = i_rdata;
      prev_d = d_rdata;
      @(negedge clk);
      if (is_d) begin
         d_req = 1; d_wr = wr; d_addr = addr; d_wdata = wdata;
      end else begin
         i_req = 1; i_addr = addr;
      end
      n = 0; en_at = -1; got = 0; wr_at_en = 0;
      while (n < 40 && !got) begin
         @(negedge clk);
         n++;
         if (mem_en && en_at < 0) begin en_at = n; wr_at_en = mem_wr; end
         if (is_d ? d_valid : i_valid) got = 1;
      end
      if (is_d) d_req = 0; else i_req = 0;
      tests++;
      if (!got || n != LAT + 2) begin
         fails++; $display("FAIL %s latency: got=%0b cycles=%0d want=%0d", nm, got, n, LAT + 2);
      end
      tests++;
      if (en_at != 1 || wr_at_en !== (is_d & wr)) begin
         fails++; $display("FAIL %s mem_en: at=%0d wr=%0b want at=1 wr=%0b", nm, en_at, wr_at_en, is_d & wr);
      end
      if (is_d && wr) begin
         ref_mem[addr] = wdata;
         tests++;
         if (d_rdata !== prev_d) begin
            fails++; $display("FAIL %s store d_rdata: %h want %h", nm, d_rdata, prev_d);
         end
      end else begin
         tests++;
         if ((is_d ? d_rdata : i_rdata) !== ref_mem[addr]) begin
            fails++; $display("FAIL %s rdata: %h want %h", nm, is_d ? d_rdata : i_rdata, ref_mem[addr]);
         end
      end
      tests++;
      if ((is_d ? i_rdata : d_rdata) !== (is_d ? prev_i : prev_d)) begin
         fails++; $display("FAIL %s other rdata moved: %h want %h", nm, is_d ? i_rdata : d_rdata, is_d ? prev_i : prev_d);
      end
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst = 1;
      @(negedge clk);
      @(negedge clk);
      rst = 0;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      tests++;
      if ({mem_en, mem_wr, busy, i_valid, d_valid} !== 5'b0 || mem_addr !== 0 || mem_wdata !== 0
          || i_rdata !== 0 || d_rdata !== 0 || mem_en1 !== 0 || busy1 !== 0) begin
         fails++; $display("FAIL reset outputs: en=%b wr=%b busy=%b iv=%b dv=%b addr=%h wd=%h ir=%h dr=%h want all 0",
                           mem_en, mem_wr, busy, i_valid, d_valid, mem_addr, mem_wdata, i_rdata, d_rdata);
      end
      rst = 0;
      @(negedge clk);
      tests++;
      if (busy !== 0 || mem_en !== 0) begin
         fails++; $display("FAIL idle after reset: busy=%b en=%b want 0", busy, mem_en);
      end
   endtask

   task automatic test_single_fetch();
      access(0, 0, 16'h0010, 16'h0000, "single_fetch");
      tests++;
      if (i_rdata !== 16'hA5A5) begin
         fails++; $display("FAIL single_fetch value: %h want a5a5", i_rdata);
      end
   endtask

   task automatic test_store_load();
      access(1, 1, 16'h0020, 16'h1234, "store");
      access(1, 0, 16'h0020, 16'h0000, "load");
      tests++;
      if (d_rdata !== 16'h1234) begin
         fails++; $display("FAIL store_load value: %h want 1234", d_rdata);
      end
   endtask

   task automatic test_random();
      for (int t = 0; t < 24; t++) begin
         bit is_d, wr;
         logic [15:0] a;
         is_d = 1'($urandom);
         wr   = is_d & 1'($urandom);
         a    = 16'h0100 + 16'($urandom_range(0, 7) * 2);
         access(is_d, wr, a, 16'($urandom), "random");
      end
   endtask

   task automatic test_conflict();
      int n, nv, ni, en_cnt;
      int en_cyc[$];
      byte order[$];
      byte exp_order[4];
      string got_s, exp_s;
      pulse_reset();
      @(negedge clk);
      i_req = 1; i_addr = 16'h0040;
      d_req = 1; d_wr = 0; d_addr = 16'h0050;
      n = 0; nv = 0; ni = 0;
      while (n < 60 && nv < 4) begin
         @(negedge clk);
         n++;
         if (mem_en) en_cyc.push_back(n);
         if (i_valid) begin order.push_back("I"); ni++; nv++; end
         if (d_valid) begin order.push_back("D"); nv++; end
      end
      i_req = 0; d_req = 0;
`ifdef MEM_ARB_RR_EN
      exp_order = '{"I", "D", "I", "D"};
`else
      exp_order = '{"D", "D", "D", "D"};
`endif
      got_s = ""; exp_s = "";
      foreach (order[k]) got_s = {got_s, string'(order[k])};
      foreach (exp_order[k]) exp_s = {exp_s, string'(exp_order[k])};
      tests++;
      if (got_s != exp_s) begin
         fails++; $display("FAIL conflict order: %s want %s", got_s, exp_s);
      end
`ifndef MEM_ARB_RR_EN
      tests++;
      if (ni != 0) begin
         fails++; $display("FAIL conflict starve: i_valid pulses %0d want 0", ni);
      end
`endif
      en_cnt = en_cyc.size();
      tests++;
      if (en_cnt < 4 || en_cyc[0] != 1) begin
         fails++; $display("FAIL conflict first grant: count=%0d first=%0d want >=4 at 1", en_cnt, en_cnt > 0 ? en_cyc[0] : -1);
      end
      for (int k = 1; k < en_cnt; k++) begin
         tests++;
         if (en_cyc[k] - en_cyc[k-1] != LAT + 3) begin
            fails++; $display("FAIL conflict spacing: %0d want %0d", en_cyc[k] - en_cyc[k-1], LAT + 3);
         end
      end
      tests++;
      if (d_rdata !== ref_mem[16'h0050]) begin
         fails++; $display("FAIL conflict d data: %h want %h", d_rdata, ref_mem[16'h0050]);
      end
   endtask

   task automatic test_halt();
      int n, en_n;
      bit got;
      @(negedge clk);
      i_req = 1; i_addr = 16'h0060;
      n = 0; got = 0;
      while (n < 40 && !got) begin
         @(negedge clk);
         n++;
         if (n == 2) hlt = 1;
         if (i_valid) got = 1;
      end
      tests++;
      if (!got || n != LAT + 2 || i_rdata !== ref_mem[16'h0060]) begin
         fails++; $display("FAIL halt inflight: got=%0b cycles=%0d data=%h want 1/%0d/%h", got, n, i_rdata, LAT + 2, ref_mem[16'h0060]);
      end
      en_n = 0;
      repeat (15) begin
         @(negedge clk);
         if (mem_en) en_n++;
      end
      tests++;
      if (en_n != 0 || busy !== 0) begin
         fails++; $display("FAIL halt blocks I: mem_en=%0d busy=%b want 0", en_n, busy);
      end
      access(1, 0, 16'h0070, 16'h0000, "halt_d");
      hlt = 0; i_req = 0;
   endtask

   task automatic test_reset_mid();
      int vcnt;
      @(negedge clk);
      i_req = 1; i_addr = 16'h0080;
      repeat (3) @(negedge clk);
      rst = 1;
      #1;
      tests++;
      if ({mem_en, busy, i_valid, d_valid} !== 4'b0) begin
         fails++; $display("FAIL reset_mid outputs: en=%b busy=%b iv=%b dv=%b want 0", mem_en, busy, i_valid, d_valid);
      end
      i_req = 0;
      @(negedge clk);
      @(negedge clk);
      rst = 0;
      vcnt = 0;
      repeat (10) begin
         @(negedge clk);
         if (i_valid || d_valid || mem_en) vcnt++;
      end
      tests++;
      if (vcnt != 0) begin
         fails++; $display("FAIL reset_mid dropped: activity=%0d want 0", vcnt);
      end
      access(0, 0, 16'h0080, 16'h0000, "reset_mid_reissue");
   endtask

   task automatic test_lat1();
      int n;
      int en_cyc[$];
      int v_cyc[$];
      @(negedge clk);
      i_req1 = 1; i_addr1 = 16'h0090;
      for (n = 1; n <= 20; n++) begin
         @(negedge clk);
         if (mem_en1) en_cyc.push_back(n);
         if (i_valid1) v_cyc.push_back(n);
      end
      i_req1 = 0;
      tests++;
      if (en_cyc.size() != 5 || v_cyc.size() != 5) begin
         fails++; $display("FAIL lat1 counts: en=%0d valid=%0d want 5/5", en_cyc.size(), v_cyc.size());
      end else begin
         for (int k = 0; k < 5; k++) begin
            tests++;
            if (en_cyc[k] != 1 + 4 * k || v_cyc[k] != en_cyc[k] + 2) begin
               fails++; $display("FAIL lat1 timing %0d: en=%0d valid=%0d want %0d/%0d", k, en_cyc[k], v_cyc[k], 1 + 4 * k, 3 + 4 * k);
            end
         end
      end
      tests++;
      if (i_rdata1 !== ref_mem[16'h0090]) begin
         fails++; $display("FAIL lat1 data: %h want %h", i_rdata1, ref_mem[16'h0090]);
      end
   endtask

   task automatic test_wr_qualifier();
      tests++;
      if (wr_viol != 0) begin
         fails++; $display("FAIL mem_wr without mem_en: %0d cycles want 0", wr_viol);
      end
   endtask

   initial begin
      for (int a = 0; a < 65536; a++) begin
         mem0[a]    = 16'(a * 16'h9E37) ^ 16'h3C5A;
         ref_mem[a] = 16'(a * 16'h9E37) ^ 16'h3C5A;
      end
      mem0[16'h0010]    = 16'hA5A5;
      ref_mem[16'h0010] = 16'hA5A5;
      for (int k = 1; k <= LAT; k++) pipe0[k] = 16'h0;
      pipe1 = 16'h0;

      test_reset();
      test_single_fetch();
      test_store_load();
      test_random();
      test_conflict();
      test_halt();
      test_reset_mid();
      test_lat1();
      test_wr_qualifier();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
